// File: rtl/qa_drv_mem_read_arbiter.sv
// Round-robin read arbiter: N clients share one downstream read port.
// Each accepted read pushes its client ID into a FIFO. Downstream responses
// come back in order, so each response pops the head ID and is steered to
// that client one cycle later.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cli_req_valid/addr/cached/check_order - per-client read requests
//   cli_req_grant              - one-hot accept, combinational, same cycle
//   cli_rsp_valid/cli_rsp_data - one-hot response strobe and shared data
//   mem_read_req_*             - downstream request (enable is combinational)
//   mem_read_rsp_data/rdy      - downstream in-order responses
//   outstanding                - reads currently tracked
//   err_unexpected_rsp         - sticky, set by a response with nothing tracked
module qa_drv_mem_read_arbiter #(
    parameter int unsigned N_CLIENTS       = 4,
    parameter int unsigned ADDR_WIDTH      = 58,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_CLIENTS-1:0]                  cli_req_valid,
    input  logic [N_CLIENTS-1:0][ADDR_WIDTH-1:0]  cli_req_addr,
    input  logic [N_CLIENTS-1:0]                  cli_req_cached,
    input  logic [N_CLIENTS-1:0]                  cli_req_check_order,
    output logic [N_CLIENTS-1:0]                  cli_req_grant,
    output logic [N_CLIENTS-1:0]                  cli_rsp_valid,
    output logic [DATA_WIDTH-1:0]                 cli_rsp_data,
    output logic [ADDR_WIDTH-1:0]                 mem_read_req_addr,
    output logic                                  mem_read_req_cached,
    output logic                                  mem_read_req_check_order,
    input  logic                                  mem_read_req_rdy,
    output logic                                  mem_read_req_enable,
    input  logic [DATA_WIDTH-1:0]                 mem_read_rsp_data,
    input  logic                                  mem_read_rsp_rdy,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  err_unexpected_rsp
);

    localparam int unsigned ID_W    = $clog2(N_CLIENTS);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    ptr_next;
    logic               issue;
    logic               pop;
    logic               unexpected;
    int                 idx;
    logic               found;

    logic [ID_W-1:0]    id_fifo [MAX_OUTSTANDING];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    // Full check uses the registered count, so a same-cycle pop cannot
    // open a grant slot until the following cycle.
    assign issue = !reset && mem_read_req_rdy
                 && (outstanding < CNT_W'(MAX_OUTSTANDING))
                 && (|cli_req_valid);

    assign pop        = !reset && mem_read_rsp_rdy && (outstanding != '0);
    assign unexpected = !reset && mem_read_rsp_rdy && (outstanding == '0);

    // Round-robin scan starting at ptr; first valid client wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < int'(N_CLIENTS); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(N_CLIENTS)) begin
                idx = idx - int'(N_CLIENTS);
            end
            if (!found && cli_req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign ptr_next = (int'(winner) == int'(N_CLIENTS) - 1) ? '0 : winner + 1'b1;

    assign cli_req_grant            = issue ? (N_CLIENTS'(1) << winner) : '0;
    assign mem_read_req_enable      = issue;
    assign mem_read_req_addr        = cli_req_addr[winner];
    assign mem_read_req_cached      = cli_req_cached[winner];
    assign mem_read_req_check_order = cli_req_check_order[winner];

    // Control state: pointers, counter, response strobe, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr                <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            outstanding        <= '0;
            cli_rsp_valid      <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (issue) begin
                ptr    <= ptr_next;
                wr_ptr <= (wr_ptr == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == FIFO_AW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            cli_rsp_valid <= pop ? (N_CLIENTS'(1) << id_fifo[rd_ptr]) : '0;
            if (unexpected) begin
                err_unexpected_rsp <= 1'b1;
            end
        end
    end

    // ID storage; occupancy is governed by the reset pointers and counter.
    always_ff @(posedge clk) begin
        if (issue) begin
            id_fifo[wr_ptr] <= winner;
        end
    end

    // Response data is only meaningful alongside cli_rsp_valid.
    always_ff @(posedge clk) begin
        if (pop) begin
            cli_rsp_data <= mem_read_rsp_data;
        end
    end

endmodule

// File: tb/tb_qa_drv_mem_read_arbiter.sv
// Bench for qa_drv_mem_read_arbiter: directed scenarios plus a randomized
// run, checked against a queue-based reference model of the arbiter.
module tb_qa_drv_mem_read_arbiter;

    localparam int N    = 4;
    localparam int AW   = 58;
    localparam int DW   = 512;
    localparam int MAXO = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0]         req_cached;
    logic [N-1:0]         req_co;
    logic [N-1:0]         grant;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic [AW-1:0]        mem_addr;
    logic                 mem_cached;
    logic                 mem_co;
    logic                 mem_rdy;
    logic                 mem_en;
    logic [DW-1:0]        mem_rsp_data;
    logic                 mem_rsp_rdy;
    logic [6:0]           outstanding;
    logic                 err;

    always #5 clk = ~clk;

    qa_drv_mem_read_arbiter dut (
        .clk                      (clk),
        .reset                    (reset),
        .cli_req_valid            (req_valid),
        .cli_req_addr             (req_addr),
        .cli_req_cached           (req_cached),
        .cli_req_check_order      (req_co),
        .cli_req_grant            (grant),
        .cli_rsp_valid            (rsp_valid),
        .cli_rsp_data             (rsp_data),
        .mem_read_req_addr        (mem_addr),
        .mem_read_req_cached      (mem_cached),
        .mem_read_req_check_order (mem_co),
        .mem_read_req_rdy         (mem_rdy),
        .mem_read_req_enable      (mem_en),
        .mem_read_rsp_data        (mem_rsp_data),
        .mem_read_rsp_rdy         (mem_rsp_rdy),
        .outstanding              (outstanding),
        .err_unexpected_rsp       (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            q[$];
    int            m_ptr = 0;
    bit            m_err = 1'b0;
    logic [N-1:0]  m_rv = '0;
    logic [DW-1:0] m_data = '0;

    int            en_count = 0;
    logic [N-1:0]  last_grant;
    logic          last_en;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // One clock: randomize payload fields, check combinational outputs,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle();
        int           w;
        bit           iss;
        logic [N-1:0] eg;
        for (int c = 0; c < N; c++) req_addr[c] = AW'({$urandom(), $urandom()});
        req_cached   = N'($urandom());
        req_co       = N'($urandom());
        mem_rsp_data = rand_data();
        w   = -1;
        iss = !reset && mem_rdy && (q.size() < MAXO) && (req_valid != '0);
        if (iss) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (w < 0 && req_valid[c]) w = c;
            end
        end
        eg = iss ? (N'(1) << w) : '0;
        #2;
        chk("grant", DW'(grant), DW'(eg));
        chk("enable", DW'(mem_en), DW'(iss));
        if (iss) begin
            chk("addr", DW'(mem_addr), DW'(req_addr[w]));
            chk("cached", DW'(mem_cached), DW'(req_cached[w]));
            chk("check_order", DW'(mem_co), DW'(req_co[w]));
        end
        last_grant = grant;
        last_en    = mem_en;
        if (mem_en) en_count++;
        if (reset) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
            m_rv  = '0;
        end else begin
            m_rv = '0;
            if (mem_rsp_rdy) begin
                if (q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_rv   = N'(1) << q.pop_front();
                    m_data = mem_rsp_data;
                end
            end
            if (iss) begin
                q.push_back(w);
                m_ptr = (w + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", DW'(rsp_valid), DW'(m_rv));
        if (m_rv != '0) chk("rsp_data", rsp_data, m_data);
        chk("outstanding", DW'(outstanding), DW'(q.size()));
        chk("err", DW'(err), DW'(m_err));
    endtask

    initial begin
        logic [N-1:0] seq [5];
        int           mode;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_cached  = '0;
        req_co      = '0;
        mem_rdy     = 1'b0;
        mem_rsp_rdy = 1'b0;
        mem_rsp_data = '0;
        repeat (2) cycle();
        reset = 1'b0;

        // All clients valid: strict rotation 0,1,2,3,0
        req_valid = 4'hF;
        mem_rdy   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rotation", DW'(last_grant), DW'(seq[i]));
        end

        // Drain
        req_valid   = '0;
        mem_rsp_rdy = 1'b1;
        repeat (5) cycle();

        // Client 2 alone, three reads, responses later in order
        mem_rsp_rdy = 1'b0;
        req_valid   = 4'b0100;
        repeat (3) cycle();
        req_valid = '0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            mem_rsp_rdy = 1'b1;
            cycle();
            chk("client2_rsp", DW'(rsp_valid), DW'(4'b0100));
            mem_rsp_rdy = 1'b0;
            cycle();
        end

        // Response with nothing tracked
        mem_rsp_rdy = 1'b1;
        cycle();
        chk("unexpected_err", DW'(err), DW'(1));
        chk("unexpected_no_rsp", DW'(rsp_valid), DW'(0));
        mem_rsp_rdy = 1'b0;
        cycle();
        chk("err_sticky", DW'(err), DW'(1));

        // Fill to the tracking limit
        en_count = 0;
        for (int i = 0; i < 68; i++) begin
            req_valid = N'($urandom_range(1, 15));
            cycle();
        end
        chk("fill_grants", DW'(en_count), DW'(64));
        chk("fill_outstanding", DW'(outstanding), DW'(64));
        req_valid   = 4'hF;
        mem_rsp_rdy = 1'b1;
        cycle();
        chk("full_pop_no_grant", DW'(last_en), DW'(0));
        mem_rsp_rdy = 1'b0;
        cycle();
        chk("grant_resumes", DW'(last_en), DW'(1));

        // Downstream not ready: no grants, pointer held
        mem_rdy     = 1'b0;
        mem_rsp_rdy = 1'b1;
        repeat (3) cycle();
        mem_rdy     = 1'b1;
        mem_rsp_rdy = 1'b0;
        cycle();

        // Reset with reads in flight
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        req_valid = 4'hF;
        repeat (5) cycle();
        chk("five_outstanding", DW'(outstanding), DW'(5));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset_outstanding", DW'(outstanding), DW'(0));
        chk("reset_rsp_valid", DW'(rsp_valid), DW'(0));
        req_valid = 4'b1010;
        cycle();
        chk("post_reset_grant", DW'(last_grant), DW'(4'b0010));
        req_valid   = '0;
        mem_rsp_rdy = 1'b1;
        repeat (2) cycle();
        chk("post_reset_err", DW'(err), DW'(1));

        // Randomized traffic with bursty response pressure
        mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) mode = int'($urandom_range(0, 2));
            reset       = ($urandom_range(0, 249) == 0);
            req_valid   = N'($urandom());
            mem_rdy     = ($urandom_range(0, 3) != 0);
            mem_rsp_rdy = (mode == 0) ? ($urandom_range(0, 5) == 0)
                        : (mode == 1) ? ($urandom_range(0, 1) == 0)
                        :               ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
